// File: rtl/axi4_slave_mem_if.sv
// rtl/axi4_slave_mem_if.sv - AXI4 write/read channel bundle for axi4_slave_mem
interface axi4_slave_mem_if #(
    parameter int ADDRESS    = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ADDRESS-1:0]      S_AWADDR;
    logic [ID_WIDTH-1:0]     S_AWID;
    logic [7:0]              S_AWLEN;
    logic                    S_AWVALID;
    logic                    S_AWREADY;
    logic [DATA_WIDTH-1:0]   S_WDATA;
    logic [DATA_WIDTH/8-1:0] S_WSTRB;
    logic                    S_WLAST;
    logic                    S_WVALID;
    logic                    S_WREADY;
    logic [ID_WIDTH-1:0]     S_BID;
    logic [1:0]              S_BRESP;
    logic                    S_BVALID;
    logic                    S_BREADY;
    logic [ADDRESS-1:0]      S_ARADDR;
    logic [ID_WIDTH-1:0]     S_ARID;
    logic [7:0]              S_ARLEN;
    logic                    S_ARVALID;
    logic                    S_ARREADY;
    logic [DATA_WIDTH-1:0]   S_RDATA;
    logic [ID_WIDTH-1:0]     S_RID;
    logic [1:0]              S_RRESP;
    logic                    S_RLAST;
    logic                    S_RVALID;
    logic                    S_RREADY;

    modport master (
        output S_AWADDR, S_AWID, S_AWLEN, S_AWVALID, input S_AWREADY,
        output S_WDATA, S_WSTRB, S_WLAST, S_WVALID, input S_WREADY,
        input S_BID, S_BRESP, S_BVALID, output S_BREADY,
        output S_ARADDR, S_ARID, S_ARLEN, S_ARVALID, input S_ARREADY,
        input S_RDATA, S_RID, S_RRESP, S_RLAST, S_RVALID, output S_RREADY
    );

    modport slave (
        input S_AWADDR, S_AWID, S_AWLEN, S_AWVALID, output S_AWREADY,
        input S_WDATA, S_WSTRB, S_WLAST, S_WVALID, output S_WREADY,
        output S_BID, S_BRESP, S_BVALID, input S_BREADY,
        input S_ARADDR, S_ARID, S_ARLEN, S_ARVALID, output S_ARREADY,
        output S_RDATA, S_RID, S_RRESP, S_RLAST, S_RVALID, input S_RREADY
    );
endinterface

// File: rtl/axi4_slave_mem.sv
// rtl/axi4_slave_mem.sv - AXI4 INCR-burst responder over a word-addressed memory
// Optional upper-address range check: AXI4_SLAVE_RANGE_CHECK_EN.
module axi4_slave_mem #(
    parameter int ADDRESS    = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DEPTH      = 256
) (
    input  logic           ACLK,
    input  logic           ARESET,
    axi4_slave_mem_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
`ifdef AXI4_SLAVE_RANGE_CHECK_EN
    localparam int WW = ADDRESS - 2;
`else
    localparam int WW = IW;
`endif

    typedef enum logic [1:0] {IDLE, W_DATA, W_RESP, R_DATA} state_t;

    state_t state_q, state_d;
    logic   ready_en_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ID_WIDTH-1:0]   id_q;
    logic [7:0]            len_q;
    logic [7:0]            cnt_q;
    logic [WW-1:0]         word_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rlast_q;
    logic [1:0]            rresp_q;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, w_last;
    logic [WW-1:0]         aw_word, ar_word, nxt_word;
    logic                  ar_oor, nxt_oor, w_oor;
    logic [DATA_WIDTH-1:0] ar_data, nxt_data;
    logic                  unused_addr;

    // Readies are held low until the first clock after reset release.
    assign bus.S_AWREADY = ready_en_q && (state_q == IDLE);
    assign bus.S_ARREADY = ready_en_q && (state_q == IDLE) && !bus.S_AWVALID;
    assign bus.S_WREADY  = (state_q == W_DATA);
    assign bus.S_BVALID  = (state_q == W_RESP);
    assign bus.S_RVALID  = (state_q == R_DATA);
    assign bus.S_BID     = id_q;
    assign bus.S_BRESP   = {err_q, 1'b0};
    assign bus.S_RID     = id_q;
    assign bus.S_RDATA   = rdata_q;
    assign bus.S_RLAST   = rlast_q;
    assign bus.S_RRESP   = rresp_q;

    assign aw_hs  = bus.S_AWVALID && bus.S_AWREADY;
    assign ar_hs  = bus.S_ARVALID && bus.S_ARREADY;
    assign w_hs   = bus.S_WVALID  && bus.S_WREADY;
    assign b_hs   = bus.S_BVALID  && bus.S_BREADY;
    assign r_hs   = bus.S_RVALID  && bus.S_RREADY;
    assign w_last = (cnt_q == len_q);

    assign aw_word  = bus.S_AWADDR[2 +: WW];
    assign ar_word  = bus.S_ARADDR[2 +: WW];
    assign nxt_word = word_q + WW'(1);

`ifdef AXI4_SLAVE_RANGE_CHECK_EN
    assign ar_oor      = |ar_word[WW-1:IW];
    assign nxt_oor     = |nxt_word[WW-1:IW];
    assign w_oor       = |word_q[WW-1:IW];
    assign unused_addr = ^{bus.S_AWADDR[1:0], bus.S_ARADDR[1:0]};
`else
    assign ar_oor      = 1'b0;
    assign nxt_oor     = 1'b0;
    assign w_oor       = 1'b0;
    assign unused_addr = ^{bus.S_AWADDR[1:0], bus.S_AWADDR[ADDRESS-1:2+IW],
                           bus.S_ARADDR[1:0], bus.S_ARADDR[ADDRESS-1:2+IW]};
`endif

    assign ar_data  = ar_oor  ? '0 : mem[ar_word[IW-1:0]];
    assign nxt_data = nxt_oor ? '0 : mem[nxt_word[IW-1:0]];

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q    <= IDLE;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (aw_hs)      state_d = W_DATA;
                else if (ar_hs) state_d = R_DATA;
            end
            W_DATA:  if (w_hs && w_last)  state_d = W_RESP;
            W_RESP:  if (b_hs)            state_d = IDLE;
            R_DATA:  if (r_hs && rlast_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            id_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            rlast_q <= 1'b0;
            rresp_q <= 2'b00;
        end else if (aw_hs) begin
            id_q   <= bus.S_AWID;
            len_q  <= bus.S_AWLEN;
            word_q <= aw_word;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else if (w_hs) begin
            word_q <= nxt_word;
            cnt_q  <= cnt_q + 8'd1;
            // Burst length follows the beat count; a misplaced WLAST only flags an error.
            if ((bus.S_WLAST != w_last) || w_oor) err_q <= 1'b1;
        end else if (ar_hs) begin
            id_q    <= bus.S_ARID;
            len_q   <= bus.S_ARLEN;
            word_q  <= ar_word;
            cnt_q   <= '0;
            rdata_q <= ar_data;
            rlast_q <= (bus.S_ARLEN == 8'd0);
            rresp_q <= ar_oor ? 2'b10 : 2'b00;
        end else if (r_hs && !rlast_q) begin
            word_q  <= nxt_word;
            cnt_q   <= cnt_q + 8'd1;
            rdata_q <= nxt_data;
            rlast_q <= ((cnt_q + 8'd1) == len_q);
            rresp_q <= nxt_oor ? 2'b10 : 2'b00;
        end
    end

    // Memory has no reset; writes already made survive a mid-burst reset.
    always_ff @(posedge ACLK) begin
        if (w_hs && !w_oor) begin
            for (int i = 0; i < DATA_WIDTH / 8; i++) begin
                if (bus.S_WSTRB[i]) mem[word_q[IW-1:0]][8*i +: 8] <= bus.S_WDATA[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axi4_slave_mem.sv
// tb/tb_axi4_slave_mem.sv - directed and randomized checks of axi4_slave_mem against a memory model
module tb_axi4_slave_mem;
    localparam int DEPTH = 256;
`ifdef AXI4_SLAVE_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic ACLK = 1'b0;
    logic ARESET;
    always #5 ACLK = ~ACLK;

    axi4_slave_mem_if #(.ADDRESS(32), .DATA_WIDTH(32), .ID_WIDTH(4)) bus ();

    axi4_slave_mem #(.ADDRESS(32), .DATA_WIDTH(32), .ID_WIDTH(4), .DEPTH(DEPTH)) dut (
        .ACLK  (ACLK),
        .ARESET(ARESET),
        .bus   (bus)
    );

    logic [31:0] model [DEPTH];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit out_of_range(input logic [31:0] a);
        return RC && (a >= 32'(DEPTH * 4));
    endfunction

    // Called and returns on a falling edge.
    task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [31:0] data[$], input logic [3:0] strb[$],
                            input int last_beat, input bit with_ar);
        bit err = 0;
        int waitc = 0;
        logic [31:0] a;
        bus.S_AWADDR = addr; bus.S_AWID = id; bus.S_AWLEN = len; bus.S_AWVALID = 1'b1;
        if (with_ar) begin
            bus.S_ARADDR = addr; bus.S_ARID = id; bus.S_ARLEN = len; bus.S_ARVALID = 1'b1;
        end
        #1;
        check("ar_blocked_by_aw", bus.S_ARREADY, 0);
        while (!bus.S_AWREADY && waitc < 20) begin @(negedge ACLK); #1; waitc++; end
        check("awready", bus.S_AWREADY, 1);
        @(posedge ACLK); @(negedge ACLK);
        bus.S_AWVALID = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            bus.S_WVALID = 1'b1; bus.S_WDATA = data[k]; bus.S_WSTRB = strb[k];
            bus.S_WLAST = (k == last_beat);
            check("wready", bus.S_WREADY, 1);
            check("bvalid_early", bus.S_BVALID, 0);
            a = addr + 32'(4 * k);
            if ((k == last_beat) != (k == int'(len))) err = 1;
            if (out_of_range(a)) err = 1;
            else for (int b = 0; b < 4; b++)
                if (strb[k][b]) model[(a >> 2) % DEPTH][8*b +: 8] = data[k][8*b +: 8];
            @(posedge ACLK); @(negedge ACLK);
        end
        bus.S_WVALID = 1'b0; bus.S_WLAST = 1'b0;
        check("wready_after", bus.S_WREADY, 0);
        for (int s = $urandom_range(0, 2); s > 0; s--) begin
            check("bvalid_hold", bus.S_BVALID, 1);
            @(posedge ACLK); @(negedge ACLK);
        end
        check("bvalid", bus.S_BVALID, 1);
        check("bid", bus.S_BID, 32'(id));
        check("bresp", bus.S_BRESP, err ? 32'd2 : 32'd0);
        bus.S_BREADY = 1'b1;
        @(posedge ACLK); @(negedge ACLK);
        bus.S_BREADY = 1'b0;
        check("bvalid_drop", bus.S_BVALID, 0);
    endtask

    // mode 0: RREADY high, 1: toggle 1010..., 2: random
    task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input int mode);
        int waitc = 0;
        int k = 0;
        int cyc = 0;
        bit rr;
        logic [31:0] a;
        bus.S_ARADDR = addr; bus.S_ARID = id; bus.S_ARLEN = len; bus.S_ARVALID = 1'b1;
        #1;
        while (!bus.S_ARREADY && waitc < 20) begin @(negedge ACLK); #1; waitc++; end
        check("arready", bus.S_ARREADY, 1);
        @(posedge ACLK); @(negedge ACLK);
        bus.S_ARVALID = 1'b0;
        while (k <= int'(len) && cyc < 2000) begin
            rr = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
            bus.S_RREADY = rr;
            a = addr + 32'(4 * k);
            check("rvalid", bus.S_RVALID, 1);
            check("rdata", bus.S_RDATA, out_of_range(a) ? 32'd0 : model[(a >> 2) % DEPTH]);
            check("rresp", bus.S_RRESP, out_of_range(a) ? 32'd2 : 32'd0);
            check("rlast", bus.S_RLAST, 32'(k == int'(len)));
            check("rid", bus.S_RID, 32'(id));
            @(posedge ACLK); @(negedge ACLK);
            if (rr) k++;
            cyc++;
        end
        check("read_beats", 32'(k), 32'(len) + 32'd1);
        bus.S_RREADY = 1'b0;
        check("rvalid_drop", bus.S_RVALID, 0);
    endtask

    initial begin
        logic [31:0] d[$];
        logic [3:0]  s[$];
        logic [31:0] a;
        logic [7:0]  len;
        int lb;

        ARESET = 1'b1;
        bus.S_AWADDR = '0; bus.S_AWID = '0; bus.S_AWLEN = '0; bus.S_AWVALID = 1'b0;
        bus.S_WDATA = '0; bus.S_WSTRB = '0; bus.S_WLAST = 1'b0; bus.S_WVALID = 1'b0;
        bus.S_BREADY = 1'b0;
        bus.S_ARADDR = '0; bus.S_ARID = '0; bus.S_ARLEN = '0; bus.S_ARVALID = 1'b0;
        bus.S_RREADY = 1'b0;

        // Reset values
        @(negedge ACLK); @(negedge ACLK);
        check("rst_awready", bus.S_AWREADY, 0);
        check("rst_arready", bus.S_ARREADY, 0);
        check("rst_wready", bus.S_WREADY, 0);
        check("rst_bvalid", bus.S_BVALID, 0);
        check("rst_rvalid", bus.S_RVALID, 0);
        check("rst_rdata", bus.S_RDATA, 0);
        check("rst_rlast", bus.S_RLAST, 0);
        check("rst_bresp", bus.S_BRESP, 0);
        check("rst_bid", bus.S_BID, 0);
        check("rst_rid", bus.S_RID, 0);
        ARESET = 1'b0;
        #1;
        check("rel_awready_low", bus.S_AWREADY, 0);
        @(negedge ACLK);
        check("rel_awready_high", bus.S_AWREADY, 1);
        check("rel_arready_high", bus.S_ARREADY, 1);

        // Fill the whole memory so every later read has a defined model value
        d.delete(); s.delete();
        for (int i = 0; i < DEPTH; i++) begin d.push_back($urandom); s.push_back(4'hf); end
        do_write(32'h0, 4'h1, 8'(DEPTH - 1), d, s, DEPTH - 1, 1'b0);

        // Single write then read
        d = '{32'hDEADBEEF}; s = '{4'hf};
        do_write(32'h10, 4'h3, 8'd0, d, s, 0, 1'b0);
        do_read(32'h10, 4'h3, 8'd0, 0);
        check("single_rd_value", model[4], 32'hDEADBEEF);

        // Strobes over zero
        d = '{32'h0}; s = '{4'hf};
        do_write(32'h0, 4'h2, 8'd0, d, s, 0, 1'b0);
        d = '{32'h11223344}; s = '{4'b0101};
        do_write(32'h0, 4'h2, 8'd0, d, s, 0, 1'b0);
        check("strobe_model", model[0], 32'h00220044);
        do_read(32'h0, 4'h5, 8'd0, 0);

        // 4-beat burst, read back with RREADY toggling
        d = '{32'd1, 32'd2, 32'd3, 32'd4}; s = '{4'hf, 4'hf, 4'hf, 4'hf};
        do_write(32'h20, 4'h6, 8'd3, d, s, 3, 1'b0);
        do_read(32'h20, 4'h6, 8'd3, 1);

        // Simultaneous AW/AR, early WLAST on a 2-beat write
        d = '{32'hA5A5_0001, 32'h5A5A_0002}; s = '{4'hf, 4'hf};
        do_write(32'h40, 4'h9, 8'd1, d, s, 0, 1'b1);
        do_read(32'h40, 4'h9, 8'd1, 0);

        // Reset during beat 2 of an 8-beat read
        bus.S_ARADDR = 32'h80; bus.S_ARID = 4'h7; bus.S_ARLEN = 8'd7; bus.S_ARVALID = 1'b1;
        @(posedge ACLK); @(negedge ACLK);
        bus.S_ARVALID = 1'b0; bus.S_RREADY = 1'b1;
        check("mid_rd_beat1", bus.S_RDATA, model[32]);
        @(posedge ACLK); @(negedge ACLK);
        check("mid_rd_beat2", bus.S_RDATA, model[33]);
        ARESET = 1'b1;
        #1;
        check("mid_rst_rvalid", bus.S_RVALID, 0);
        check("mid_rst_rdata", bus.S_RDATA, 0);
        bus.S_RREADY = 1'b0;
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        do_read(32'h84, 4'hB, 8'd2, 0);

        // Address above the memory: aliased or range-errored
        do_read(32'h400, 4'hC, 8'd0, 0);
        do_read(32'h3F8, 4'hD, 8'd3, 0);

        // Randomized bursts, some wrapping/crossing the top
        for (int it = 0; it < 10; it++) begin
            len = 8'($urandom_range(0, 7));
            a   = 32'($urandom_range(0, DEPTH + 7)) << 2;
            lb  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : int'(len);
            d.delete(); s.delete();
            for (int k = 0; k <= int'(len); k++) begin
                d.push_back($urandom);
                s.push_back(4'($urandom_range(0, 15)));
            end
            do_write(a, 4'($urandom_range(0, 15)), len, d, s, lb, 1'b0);
            do_read(a, 4'($urandom_range(0, 15)), len, 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axi4_slave_mem.md
# axi4_slave_mem

AXI4 responder with an internal word-addressed memory, the counterpart to the team's AXI4 master. It accepts single or INCR bursts on the write and read channels, applies byte strobes, echoes transaction IDs, and returns data and responses. It is used as a bench target for the master and as the register/buffer front end ahead of the SPI engine.

## Interface
- `ADDRESS`, 32: address width.
- `DATA_WIDTH`, 32: data width. Fixed at 32; four strobe bits.
- `ID_WIDTH`, 4: ID width.
- `DEPTH`, 256: memory words. Power of two, at least 2.
- `ACLK`, in, 1: clock.
- `ARESET`, in, 1: reset. One clock; reset is asynchronous and active-high.
- `S_AWADDR`, in, ADDRESS / `S_AWID`, in, ID_WIDTH / `S_AWLEN`, in, 8 / `S_AWVALID`, in, 1: write address.
- `S_AWREADY`, out, 1: write address accept.
- `S_WDATA`, in, 32 / `S_WSTRB`, in, 4 / `S_WLAST`, in, 1 / `S_WVALID`, in, 1: write data.
- `S_WREADY`, out, 1: write data accept.
- `S_BID`, out, ID_WIDTH / `S_BRESP`, out, 2 / `S_BVALID`, out, 1: write response.
- `S_BREADY`, in, 1: write response accept.
- `S_ARADDR`, in, ADDRESS / `S_ARID`, in, ID_WIDTH / `S_ARLEN`, in, 8 / `S_ARVALID`, in, 1: read address.
- `S_ARREADY`, out, 1: read address accept.
- `S_RDATA`, out, 32 / `S_RID`, out, ID_WIDTH / `S_RRESP`, out, 2 / `S_RLAST`, out, 1 / `S_RVALID`, out, 1: read data.
- `S_RREADY`, in, 1: read data accept.

## Operation
- Word index is `addr[2 +: log2(DEPTH)]`. Bursts are INCR with a 4-byte step; the beat count is LEN+1 (1..256).
- FSM states:
  - IDLE goes to W_DATA on an AW handshake, or to R_DATA on an AR handshake.
  - W_DATA goes to W_RESP when the beat with count==LEN is accepted.
  - W_RESP goes to IDLE on a B handshake.
  - R_DATA goes to IDLE on the R handshake with RLAST=1.
- Ready signals are a combinational decode of state:
  - `S_AWREADY` = IDLE.
  - `S_ARREADY` = IDLE && !S_AWVALID. Write wins when both are valid in the same cycle.
  - `S_WREADY` = W_DATA.
- On AW handshake: latch ID, LEN, start index; clear the beat counter and error flag.
- On W handshake: for each byte i with WSTRB[i]=1, write `mem[idx][8i+:8]`. Then increment the index (wraps modulo DEPTH) and the beat counter.
  - WSTRB=0000 is a legal no-write beat.
  - If WLAST differs from (count==LEN), set the error flag. The burst length is decided by the count only.
- Write response: `S_BID` is the latched ID. `S_BRESP` is 2'b10 (SLVERR) if the error flag is set, else 2'b00.
- On AR handshake: latch ID, LEN, index; load `S_RDATA`=mem[index] and `S_RLAST`=(LEN==0); assert `S_RVALID`.
- On R handshake that is not last: load the next word, increment the index, set `S_RLAST`=(count+1==LEN).
- `S_RID` is the latched ID. `S_RRESP` is 2'b00 unless set by the range check.
- Outputs hold stable while VALID=1 and READY=0.
- Memory is not reset.
- Reset values: every output is 0, including AWREADY and ARREADY. While ARESET is asserted, state is forced to IDLE; the readies rise on the first clock after release.
- Reset mid-burst abandons the transaction. Memory writes already performed remain.

## Timing
- AW handshake at cycle N: `S_WREADY`=1 from N+1. Sustains one beat per cycle.
- Final W beat at cycle M: `S_BVALID`=1 at M+1, held until BREADY. IDLE follows on the cycle after the B handshake.
- AR handshake at cycle N: `S_RVALID`=1 with the first word at N+1.
- Read throughput is one beat per cycle with RREADY held high. RVALID drops the cycle after the last handshake.
- Read-after-write: a read accepted after B completes returns the new data.

## Configuration
- `AXI4_SLAVE_RANGE_CHECK_EN`:
  - Defined: compare full address bits above the index field to zero. A nonzero value means the beat is out of range.
    - Out-of-range write beats are dropped and set the error flag.
    - Out-of-range read beats return RDATA=0 and RRESP=2'b10 on that beat.
    - Checked per beat, so a burst crossing the top gets SLVERR only on the beats past the top.
  - Undefined: upper bits are ignored, the address aliases modulo DEPTH, and RRESP is always 2'b00.

## Test plan
- Single write then read: AW addr 0x10, ID 3, LEN 0; W 0xDEADBEEF, strb 1111. Expect BID=3, BRESP=00. Then AR 0x10 gives RDATA=0xDEADBEEF, RLAST=1, RID=3.
- Strobes: write 0x11223344 with strb 0101 over 0x00000000. Read returns 0x00220044.
- 4-beat burst: AW 0x20, LEN 3, data 1..4, WLAST on beat 4. Then AR 0x20, LEN 3, RREADY toggled 1010... Expect 1,2,3,4 with RLAST only on beat 4 and data held during stalls.
- Contention and WLAST error: AWVALID and ARVALID raised in the same cycle. Write is accepted first. A 2-beat write with WLAST on beat 1 gives BRESP=10, and both beats are written.
- Reset mid-read: assert ARESET during beat 2 of a LEN 7 read. RVALID=0 immediately; the next AR is accepted normally after release.
- With `AXI4_SLAVE_RANGE_CHECK_EN` and DEPTH 256: a read of addr 0x400 gives RDATA=0 and RRESP=10. Without the macro, the same read returns mem[0].
